// File: rtl/ls16x_counter.sv
// ls16x_counter: presettable counter with a programmable modulus, generalising
// the 74LS160/161/163/191 family. The clear is synchronous, the reset is
// asynchronous, and the carry output can be cascaded.
// Optional feature: define LS16X_UPDOWN_EN to add the UP port, which turns on
// LS191-style up/down counting. Without it the counter only counts up.
module ls16x_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
`ifdef LS16X_UPDOWN_EN
  input  logic             UP,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  // The highest in-range count, truncated to the counter width.
  localparam int               MAX_INT = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_INT[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             count_up;
  logic             tc;

`ifdef LS16X_UPDOWN_EN
  assign count_up = UP;
`else
  assign count_up = 1'b1;
`endif

  // The next state follows the priority clear > load > count > hold.
  // Counting up compares with >= so that an out-of-range preload returns
  // to 0 on a single count. Counting down only wraps when Q is 0.
  always_comb begin
    q_next = q_reg;
    if (CLR) begin
      q_next = '0;
    end else if (LOAD) begin
      q_next = D;
    end else if (ENP && ENT) begin
      if (count_up) begin
        q_next = (q_reg >= MAX_VAL) ? '0 : q_reg + 1'b1;
      end else begin
        q_next = (q_reg == '0) ? MAX_VAL : q_reg - 1'b1;
      end
    end
  end

  // The state register. Reset clears it immediately and does not wait for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  // The terminal count depends on the current direction. RCO is ENT gated with
  // the terminal count and does not depend on ENP, CLR or LOAD.
  always_comb begin
    tc  = count_up ? (q_reg == MAX_VAL) : (q_reg == '0);
    RCO = ENT & tc;
  end

  assign Q = q_reg;

endmodule

// File: tb/tb_ls16x_counter.sv
// Scoreboard bench for ls16x_counter.
// Unit 0: WIDTH=4, MODULUS=16. Unit 1: WIDTH=4, MODULUS=10.
// Unit 2: two MODULUS=10 stages cascaded, giving Q = {stage1, stage0}.
module tb_ls16x_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr_s [3];
  logic       load_s[3];
  logic       enp_s [3];
  logic       ent_s [3];
  logic       up_s  [3];
  logic [3:0] d_s   [3];

  logic [3:0] q0, q1, qa, qb;
  logic       rco0, rco1, rcoa, rcob;

  ls16x_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
    .CLK(clk), .RST(rst), .CLR(clr_s[0]), .LOAD(load_s[0]), .D(d_s[0]),
    .ENP(enp_s[0]), .ENT(ent_s[0]),
`ifdef LS16X_UPDOWN_EN
    .UP(up_s[0]),
`endif
    .Q(q0), .RCO(rco0));

  ls16x_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .CLK(clk), .RST(rst), .CLR(clr_s[1]), .LOAD(load_s[1]), .D(d_s[1]),
    .ENP(enp_s[1]), .ENT(ent_s[1]),
`ifdef LS16X_UPDOWN_EN
    .UP(up_s[1]),
`endif
    .Q(q1), .RCO(rco1));

  ls16x_counter #(.WIDTH(4), .MODULUS(10)) u_cas0 (
    .CLK(clk), .RST(rst), .CLR(clr_s[2]), .LOAD(load_s[2]), .D(d_s[2]),
    .ENP(enp_s[2]), .ENT(ent_s[2]),
`ifdef LS16X_UPDOWN_EN
    .UP(up_s[2]),
`endif
    .Q(qa), .RCO(rcoa));

  ls16x_counter #(.WIDTH(4), .MODULUS(10)) u_cas1 (
    .CLK(clk), .RST(rst), .CLR(clr_s[2]), .LOAD(load_s[2]), .D(d_s[2]),
    .ENP(enp_s[2]), .ENT(rcoa),
`ifdef LS16X_UPDOWN_EN
    .UP(up_s[2]),
`endif
    .Q(qb), .RCO(rcob));

  typedef struct {
    int         unit;
    int         target;
    logic [7:0] q;
    logic       rco;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [7:0] aq, input logic arco,
                       input logic [7:0] eq, input logic erco);
    tests++;
    if (aq !== eq || arco !== erco) begin
      fails++;
      $display("FAIL %s: got Q=%0h RCO=%0b, expected Q=%0h RCO=%0b", nm, aq, arco, eq, erco);
    end
  endtask

  // Monitor: each falling edge, compare every expectation that is due in this cycle.
  exp_t        mon_e;
  logic [7:0]  mon_q;
  logic        mon_r;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].target <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.unit)
        0:       begin mon_q = {4'h0, q0}; mon_r = rco0; end
        1:       begin mon_q = {4'h0, q1}; mon_r = rco1; end
        default: begin mon_q = {qb, qa};   mon_r = rcob; end
      endcase
      if (mon_e.target < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation for cycle %0d was not checked until cycle %0d", mon_e.name, mon_e.target, cyc);
      end else begin
        check(mon_e.name, mon_q, mon_r, mon_e.q, mon_e.rco);
      end
    end
  end

  // Apply one set of inputs to unit u for the next rising edge and queue the
  // expected Q and RCO after that edge. The other units are held idle.
  task automatic step(input int u, input logic clr, input logic load, input logic [3:0] d,
                      input logic enp, input logic ent, input logic up,
                      input logic [7:0] eq, input logic erco, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != u) begin
        clr_s[i] = 1'b0; load_s[i] = 1'b0; enp_s[i] = 1'b0;
      end
    end
    clr_s[u] = clr; load_s[u] = load; d_s[u] = d;
    enp_s[u] = enp; ent_s[u] = ent;   up_s[u] = up;
    e.unit = u; e.target = cyc + 1; e.q = eq; e.rco = erco; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    exp_t       e;
    int         v;
    logic [7:0] bcd;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr_s[i] = 1'b0; load_s[i] = 1'b0; enp_s[i] = 1'b0;
      ent_s[i] = 1'b0; up_s[i] = 1'b1;   d_s[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_bin", {4'h0, q0}, rco0, 8'h00, 1'b0);
    check("reset_dec", {4'h0, q1}, rco1, 8'h00, 1'b0);
    check("reset_cas", {qb, qa}, rcob, 8'h00, 1'b0);

    // Count to 7, then reset in the middle of the cycle.
    for (int k = 1; k <= 7; k++)
      step(0, 0, 0, 4'h0, 1, 1, 1, 8'(k), 1'b0, "bin_count");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {4'h0, q0}, rco0, 8'h00, 1'b0);
    #1;
    rst = 1'b0;
    e.unit = 0; e.target = cyc + 1; e.q = 8'h01; e.rco = 1'b0; e.name = "rst_first_edge";
    sb.push_back(e);
    step(0, 0, 0, 4'h0, 1, 1, 1, 8'h02, 1'b0, "rst_second_edge");

    // Binary wrap: clear first, then 17 counts.
    step(0, 1, 0, 4'h0, 1, 1, 1, 8'h00, 1'b0, "bin_clr");
    for (int k = 1; k <= 15; k++)
      step(0, 0, 0, 4'h0, 1, 1, 1, 8'(k), (k == 15), "bin_wrap_up");
    step(0, 0, 0, 4'h0, 1, 1, 1, 8'h00, 1'b0, "bin_wrap_zero");
    step(0, 0, 0, 4'h0, 1, 1, 1, 8'h01, 1'b0, "bin_wrap_one");
    step(0, 0, 1, 4'hF, 0, 0, 1, 8'h0F, 1'b0, "bin_load15_ent0");
    step(0, 0, 0, 4'h0, 1, 0, 1, 8'h0F, 1'b0, "bin_hold_ent0");
    step(0, 0, 0, 4'h0, 0, 1, 1, 8'h0F, 1'b1, "bin_hold_enp0_rco");

    // Decade counter: out-of-range load, terminal count, and priority.
    step(1, 0, 1, 4'd13, 1, 1, 1, 8'd13, 1'b0, "dec_load13");
    step(1, 0, 0, 4'd0,  1, 1, 1, 8'd0,  1'b0, "dec_recover");
    step(1, 0, 1, 4'd9,  1, 1, 1, 8'd9,  1'b1, "dec_load9_rco");
    step(1, 0, 0, 4'd0,  1, 1, 1, 8'd0,  1'b0, "dec_wrap");
    step(1, 0, 0, 4'd0,  1, 1, 1, 8'd1,  1'b0, "dec_count");
    step(1, 1, 1, 4'd5,  1, 1, 1, 8'd0,  1'b0, "prio_clr_wins");
    step(1, 0, 1, 4'd5,  1, 1, 1, 8'd5,  1'b0, "prio_load_wins");
    step(1, 0, 0, 4'd0,  0, 1, 1, 8'd5,  1'b0, "prio_hold");
`ifdef LS16X_UPDOWN_EN
    step(1, 0, 1, 4'd1,  1, 1, 1, 8'd1,  1'b0, "dn_load1");
    step(1, 0, 0, 4'd0,  1, 1, 0, 8'd0,  1'b1, "dn_to0_rco");
    step(1, 0, 0, 4'd0,  1, 1, 0, 8'd9,  1'b0, "dn_wrap9");
    step(1, 0, 0, 4'd0,  1, 1, 0, 8'd8,  1'b0, "dn_8");
    step(1, 0, 0, 4'd0,  1, 1, 1, 8'd9,  1'b1, "dn_switch_up");
    step(1, 0, 1, 4'd13, 1, 1, 0, 8'd13, 1'b0, "dn_load13");
    step(1, 0, 0, 4'd0,  1, 1, 0, 8'd12, 1'b0, "dn_oor_dec");
`endif

    // Two-stage cascade: 100 counts from 00 should step through 00..99 and back to 00.
    step(2, 1, 0, 4'h0, 1, 1, 1, 8'h00, 1'b0, "cas_clr");
    for (int k = 1; k <= 100; k++) begin
      v   = k % 100;
      bcd = 8'(((v / 10) * 16) + (v % 10));
      step(2, 0, 0, 4'h0, 1, 1, 1, bcd, (v == 99), "cas_count");
    end

    repeat (3) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
